// File: rtl/h3_table_lookup.sv
// -----------------------------------------------------------------------------
// h3_table_lookup
// Single-way hash-table engine. A request (LOOKUP / INSERT / DELETE) is
// captured on the request handshake, its key is hashed with an H3 matrix to
// select one bucket, the bucket is read, compared and (for INSERT / DELETE)
// updated, and the outcome is returned on the response handshake.
//
// Optional feature macro: H3_TABLE_STATS_EN
//   When defined, adds occupancy_o (number of valid buckets) and
//   collision_cnt_o (saturating count of COLLISION responses).
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   matrix_i            H3 matrix, one KEY_WIDTH row per address bit; must be
//                       stable while the engine is busy
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_op_i            00 LOOKUP, 01 INSERT, 10 DELETE, 11 reserved
//   req_key_i           request key
//   req_value_i         value to store on INSERT
//   resp_valid_o/ready_i response handshake; outputs held until taken
//   resp_hit_o          stored key matched
//   resp_status_o       00 OK, 01 NOT_FOUND, 10 COLLISION, 11 ILLEGAL_OP
//   resp_value_o        stored (old) value on hit, else zero
//   occupancy_o         (H3_TABLE_STATS_EN) count of valid buckets
//   collision_cnt_o     (H3_TABLE_STATS_EN) saturating collision count
// -----------------------------------------------------------------------------

module h3_hash_function #(
    parameter int KEY_WIDTH      = 32,
    parameter int HASH_ADR_WIDTH = 5
) (
    input  logic [HASH_ADR_WIDTH-1:0][KEY_WIDTH-1:0] matrix,
    input  logic [KEY_WIDTH-1:0]                     key,
    output logic [HASH_ADR_WIDTH-1:0]                hash
);

    function automatic logic parity_of(input logic [KEY_WIDTH-1:0] data);
        return ^data;
    endfunction

    // Each address bit is the parity of the key masked by its matrix row.
    always_comb begin
        hash = {HASH_ADR_WIDTH{1'b0}};
        for (int j = 0; j < HASH_ADR_WIDTH; j++) begin
            hash[j] = parity_of(key & matrix[j]);
        end
    end

endmodule

module h3_table_lookup #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int HASH_ADR_WIDTH = 5
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [HASH_ADR_WIDTH-1:0][KEY_WIDTH-1:0] matrix_i,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic [1:0]                               req_op_i,
    input  logic [KEY_WIDTH-1:0]                     req_key_i,
    input  logic [VALUE_WIDTH-1:0]                   req_value_i,
    output logic                                     resp_valid_o,
    input  logic                                     resp_ready_i,
    output logic                                     resp_hit_o,
    output logic [1:0]                               resp_status_o,
    output logic [VALUE_WIDTH-1:0]                   resp_value_o
`ifdef H3_TABLE_STATS_EN
    ,
    output logic [HASH_ADR_WIDTH:0]                  occupancy_o,
    output logic [15:0]                              collision_cnt_o
`endif
);

    localparam int DEPTH = 2 ** HASH_ADR_WIDTH;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;

    localparam logic [1:0] STS_OK        = 2'b00;
    localparam logic [1:0] STS_NOT_FOUND = 2'b01;
    localparam logic [1:0] STS_COLLISION = 2'b10;
    localparam logic [1:0] STS_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CMP  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [1:0]                op_r;
    logic [KEY_WIDTH-1:0]      key_r;
    logic [VALUE_WIDTH-1:0]    value_r;
    logic [HASH_ADR_WIDTH-1:0] adr_s;

    logic [DEPTH-1:0]          valid_r;
    logic [KEY_WIDTH-1:0]      key_mem   [DEPTH];
    logic [VALUE_WIDTH-1:0]    value_mem [DEPTH];

    logic                      rd_valid_r;
    logic [KEY_WIDTH-1:0]      rd_key_r;
    logic [VALUE_WIDTH-1:0]    rd_value_r;

    logic                      accept_s;
    logic                      resp_done_s;
    logic                      match_s;
    logic                      wr_key_s, wr_value_s, valid_set_s, valid_clr_s;
    logic                      resp_hit_s;
    logic [1:0]                resp_status_s;
    logic [VALUE_WIDTH-1:0]    resp_value_s;

    logic                      resp_valid_r, resp_hit_r;
    logic [1:0]                resp_status_r;
    logic [VALUE_WIDTH-1:0]    resp_value_r;

    // The address is recomputed from the captured key every cycle; matrix_i
    // is held stable by the feeder while busy, so READ and CMP see the same bucket.
    h3_hash_function #(
        .KEY_WIDTH      (KEY_WIDTH),
        .HASH_ADR_WIDTH (HASH_ADR_WIDTH)
    ) u_hash (
        .matrix (matrix_i),
        .key    (key_r),
        .hash   (adr_s)
    );

    assign accept_s    = (state_r == ST_IDLE) & req_valid_i;
    assign resp_done_s = (state_r == ST_RESP) & resp_valid_r & resp_ready_i;
    assign match_s     = rd_valid_r & (rd_key_r == key_r);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus the compare/update decision taken in CMP.
    always_comb begin
        state_s       = state_r;
        wr_key_s      = 1'b0;
        wr_value_s    = 1'b0;
        valid_set_s   = 1'b0;
        valid_clr_s   = 1'b0;
        resp_hit_s    = 1'b0;
        resp_status_s = STS_NOT_FOUND;
        resp_value_s  = {VALUE_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_CMP;
            end
            ST_CMP: begin
                state_s = ST_RESP;
                case (op_r)
                    OP_LOOKUP: begin
                        if (match_s) begin
                            resp_hit_s    = 1'b1;
                            resp_status_s = STS_OK;
                            resp_value_s  = rd_value_r;
                        end else begin
                            resp_status_s = STS_NOT_FOUND;
                        end
                    end
                    OP_INSERT: begin
                        if (!rd_valid_r) begin
                            wr_key_s      = 1'b1;
                            wr_value_s    = 1'b1;
                            valid_set_s   = 1'b1;
                            resp_status_s = STS_OK;
                        end else if (match_s) begin
                            // Overwrite keeps the key; the old value is returned.
                            wr_value_s    = 1'b1;
                            resp_hit_s    = 1'b1;
                            resp_status_s = STS_OK;
                            resp_value_s  = rd_value_r;
                        end else begin
                            resp_status_s = STS_COLLISION;
                        end
                    end
                    OP_DELETE: begin
                        if (match_s) begin
                            valid_clr_s   = 1'b1;
                            resp_hit_s    = 1'b1;
                            resp_status_s = STS_OK;
                            resp_value_s  = rd_value_r;
                        end else begin
                            resp_status_s = STS_NOT_FOUND;
                        end
                    end
                    default: begin
                        resp_status_s = STS_ILLEGAL;
                    end
                endcase
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture on the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r    <= 2'b00;
            key_r   <= {KEY_WIDTH{1'b0}};
            value_r <= {VALUE_WIDTH{1'b0}};
        end else if (accept_s) begin
            op_r    <= req_op_i;
            key_r   <= req_key_i;
            value_r <= req_value_i;
        end
    end

    // Bucket valid flags (cleared by reset) and the registered valid read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r    <= {DEPTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            if (state_r == ST_READ) begin
                rd_valid_r <= valid_r[adr_s];
            end
            if (valid_set_s) begin
                valid_r[adr_s] <= 1'b1;
            end else if (valid_clr_s) begin
                valid_r[adr_s] <= 1'b0;
            end
        end
    end

    // Key/value RAM: synchronous read in READ, write in CMP. Writes are gated
    // by the reset-cleared state, so an interrupted request never commits.
    always_ff @(posedge clk) begin
        if (state_r == ST_READ) begin
            rd_key_r   <= key_mem[adr_s];
            rd_value_r <= value_mem[adr_s];
        end
        if (wr_key_s) begin
            key_mem[adr_s] <= key_r;
        end
        if (wr_value_s) begin
            value_mem[adr_s] <= value_r;
        end
    end

    // Response registers: loaded leaving CMP, held through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_r  <= 1'b0;
            resp_hit_r    <= 1'b0;
            resp_status_r <= STS_OK;
            resp_value_r  <= {VALUE_WIDTH{1'b0}};
        end else if (state_r == ST_CMP) begin
            resp_valid_r  <= 1'b1;
            resp_hit_r    <= resp_hit_s;
            resp_status_r <= resp_status_s;
            resp_value_r  <= resp_value_s;
        end else if (resp_done_s) begin
            resp_valid_r  <= 1'b0;
        end
    end

    assign req_ready_o   = (state_r == ST_IDLE);
    assign resp_valid_o  = resp_valid_r;
    assign resp_hit_o    = resp_hit_r;
    assign resp_status_o = resp_status_r;
    assign resp_value_o  = resp_value_r;

`ifdef H3_TABLE_STATS_EN
    logic [HASH_ADR_WIDTH:0] occupancy_r;
    logic [15:0]             collision_cnt_r;

    // Occupancy follows the valid flags; collision count saturates at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy_r     <= {(HASH_ADR_WIDTH+1){1'b0}};
            collision_cnt_r <= 16'h0000;
        end else begin
            if (valid_set_s) begin
                occupancy_r <= occupancy_r + {{HASH_ADR_WIDTH{1'b0}}, 1'b1};
            end else if (valid_clr_s) begin
                occupancy_r <= occupancy_r - {{HASH_ADR_WIDTH{1'b0}}, 1'b1};
            end
            if ((state_r == ST_CMP) && (resp_status_s == STS_COLLISION) &&
                (collision_cnt_r != 16'hFFFF)) begin
                collision_cnt_r <= collision_cnt_r + 16'h0001;
            end
        end
    end

    assign occupancy_o     = occupancy_r;
    assign collision_cnt_o = collision_cnt_r;
`endif

endmodule

// File: tb/tb_h3_table_lookup.sv
// -----------------------------------------------------------------------------
// tb_h3_table_lookup
// Self-checking bench for h3_table_lookup. Directed steps followed by random
// traffic; every response is predicted by a bucket-array model that computes
// the H3 hash from bit counts and applies the table rules directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_h3_table_lookup;

    localparam int KW    = 32;
    localparam int VW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [AW-1:0][KW-1:0]  matrix;
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KW-1:0]          req_key;
    logic [VW-1:0]          req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_hit;
    logic [1:0]             resp_status;
    logic [VW-1:0]          resp_value;
`ifdef H3_TABLE_STATS_EN
    logic [AW:0]            occupancy;
    logic [15:0]            collision_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference table state
    bit          m_valid [DEPTH];
    logic [KW-1:0] m_key [DEPTH];
    logic [VW-1:0] m_val [DEPTH];
    int          m_occ;
    int          m_coll;

    always #5 clk = ~clk;

    h3_table_lookup #(
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .HASH_ADR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .matrix_i      (matrix),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_key_i     (req_key),
        .req_value_i   (req_value),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_hit_o    (resp_hit),
        .resp_status_o (resp_status),
        .resp_value_o  (resp_value)
`ifdef H3_TABLE_STATS_EN
        ,
        .occupancy_o     (occupancy),
        .collision_cnt_o (collision_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_hash(input logic [KW-1:0] k);
        int h = 0;
        for (int j = 0; j < AW; j++) begin
            if (($countones(k & matrix[j]) % 2) == 1) h += (1 << j);
        end
        return h;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < DEPTH; b++) m_valid[b] = 1'b0;
        m_occ  = 0;
        m_coll = 0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                            output logic ehit, output logic [1:0] est, output logic [VW-1:0] eval);
        int b;
        bit found;
        b     = m_hash(k);
        found = m_valid[b] && (m_key[b] == k);
        ehit  = 1'b0;
        est   = 2'b01;
        eval  = '0;
        case (op)
            2'b00: if (found) begin ehit = 1'b1; est = 2'b00; eval = m_val[b]; end
            2'b01: begin
                if (!m_valid[b]) begin
                    m_valid[b] = 1'b1; m_key[b] = k; m_val[b] = v; m_occ++; est = 2'b00;
                end else if (found) begin
                    ehit = 1'b1; est = 2'b00; eval = m_val[b]; m_val[b] = v;
                end else begin
                    est = 2'b10;
                    if (m_coll < 65535) m_coll++;
                end
            end
            2'b10: if (found) begin
                ehit = 1'b1; est = 2'b00; eval = m_val[b]; m_valid[b] = 1'b0; m_occ--;
            end
            default: est = 2'b11;
        endcase
    endtask

    // One full transaction: accept, latency, response contents, hold, handshake.
    task automatic do_req(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                          input int hold, output logic ohit, output logic [1:0] ost,
                          output logic [VW-1:0] oval);
        int waitn;
        int lat;
        logic ehit;
        logic [1:0] est;
        logic [VW-1:0] eval;
        @(negedge clk);
        waitn = 0;
        while (!req_ready && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        model_op(op, k, v, ehit, est, eval);
        req_valid = 1'b1; req_op = op; req_key = k; req_value = v;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        ohit = resp_hit; ost = resp_status; oval = resp_value;
        check("req_ready_busy", req_ready, 1'b0);
        check("resp_hit", resp_hit, ehit);
        check("resp_status", resp_status, est);
        check("resp_value", resp_value, eval);
`ifdef H3_TABLE_STATS_EN
        check("occupancy", occupancy, m_occ);
        check("collision_cnt", collision_cnt, m_coll);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_hit", resp_hit, ehit);
            check("hold_status", resp_status, est);
            check("hold_value", resp_value, eval);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("resp_valid_drop", resp_valid, 1'b0);
        check("req_ready_back", req_ready, 1'b1);
    endtask

    initial begin
        logic h;
        logic [1:0] s;
        logic [VW-1:0] val;
        int r;
        logic [1:0] op;

        reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_key = '0; req_value = '0;
        resp_ready = 1'b0;
        for (int j = 0; j < AW; j++) matrix[j] = 32'h1 << j;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_resp_status", resp_status, 2'b00);
        check("rst_resp_value", resp_value, 32'h0);
        reset_n = 1'b1;

        do_req(2'b00, 32'h3, 32'h0, 0, h, s, val);
        check("t_lookup_empty_status", s, 2'b01);
        check("t_lookup_empty_value", val, 32'h0);
        do_req(2'b01, 32'h3, 32'hDEAD_BEEF, 0, h, s, val);
        check("t_insert_status", s, 2'b00);
        check("t_insert_hit", h, 1'b0);
        do_req(2'b00, 32'h3, 32'h0, 0, h, s, val);
        check("t_lookup_hit_value", val, 32'hDEAD_BEEF);
        do_req(2'b01, 32'h23, 32'h1111_1111, 0, h, s, val);
        check("t_collision_status", s, 2'b10);
        do_req(2'b00, 32'h23, 32'h0, 0, h, s, val);
        check("t_lookup_coll_key", s, 2'b01);
        do_req(2'b00, 32'h3, 32'h0, 0, h, s, val);
        check("t_still_deadbeef", val, 32'hDEAD_BEEF);
        do_req(2'b01, 32'h3, 32'h2222_2222, 0, h, s, val);
        check("t_overwrite_hit", h, 1'b1);
        check("t_overwrite_old", val, 32'hDEAD_BEEF);
        do_req(2'b10, 32'h3, 32'h0, 0, h, s, val);
        check("t_delete_value", val, 32'h2222_2222);
        do_req(2'b00, 32'h3, 32'h0, 5, h, s, val);
        check("t_lookup_deleted", s, 2'b01);
        do_req(2'b11, 32'h3, 32'h5, 3, h, s, val);
        check("t_illegal", s, 2'b11);
        do_req(2'b00, 32'h3, 32'h0, 0, h, s, val);
        check("t_illegal_nochange", s, 2'b01);

        // Reset while an INSERT to empty bucket 7 sits in CMP.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_key = 32'h7; req_value = 32'h7777_7777;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_resp_valid", resp_valid, 1'b0);
        reset_n = 1'b1;
        do_req(2'b00, 32'h7, 32'h0, 0, h, s, val);
        check("t_midrst_lookup", s, 2'b01);

        // Three distinct inserts, one collision, one delete.
        do_req(2'b01, 32'h1, 32'hA1, 0, h, s, val);
        do_req(2'b01, 32'h2, 32'hA2, 0, h, s, val);
        do_req(2'b01, 32'h4, 32'hA4, 0, h, s, val);
        do_req(2'b01, 32'h21, 32'hB1, 0, h, s, val);
        check("t_stats_coll", s, 2'b10);
        do_req(2'b10, 32'h2, 32'h0, 0, h, s, val);
        check("t_stats_del", val, 32'hA2);
`ifdef H3_TABLE_STATS_EN
        check("t_occupancy_2", occupancy, 2);
        check("t_collisions_1", collision_cnt, 1);
`endif

        // Random traffic under two random matrices (changed only while idle).
        for (int phase = 0; phase < 2; phase++) begin
            @(negedge clk);
            for (int j = 0; j < AW; j++) matrix[j] = $urandom();
            for (int n = 0; n < 100; n++) begin
                r = $urandom_range(0, 9);
                if (r < 4) op = 2'b01;
                else if (r < 7) op = 2'b00;
                else if (r < 9) op = 2'b10;
                else op = 2'b11;
                do_req(op, $urandom_range(0, 63), $urandom(), $urandom_range(0, 2), h, s, val);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/h3_table_lookup.md
Name: h3_table_lookup

Overview:
- Single-way hash-table engine that consumes the H3 address produced for a key.
- Accepts LOOKUP/INSERT/DELETE requests over a valid/ready handshake.
- Hashes the registered key with an internal h3_hash_function instance and reads a bucket array of {valid, key, value}.
- Compares the stored entry and returns hit/status/value over a second valid/ready handshake.
- Sits between the request front-end and the memory-backed table.

Parameters:
KEY_WIDTH, 32, key width in bits; passed through to the H3 instance
VALUE_WIDTH, 32, stored value width in bits
HASH_ADR_WIDTH, 5, bucket address width; table depth = 2**HASH_ADR_WIDTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
matrix_i  input  KEY_WIDTH x HASH_ADR_WIDTH  H3 matrix rows; must be stable while busy
req_valid_i  input  1  request valid
req_ready_o  output  1  engine idle, request can be taken
req_op_i  input  2  00 LOOKUP, 01 INSERT, 10 DELETE, 11 reserved
req_key_i  input  KEY_WIDTH  request key
req_value_i  input  VALUE_WIDTH  insert value
resp_valid_o  output  1  response valid
resp_ready_i  input  1  consumer takes response
resp_hit_o  output  1  stored key matched
resp_status_o  output  2  00 OK, 01 NOT_FOUND, 10 COLLISION, 11 ILLEGAL_OP
resp_value_o  output  VALUE_WIDTH  stored value on hit, else 0

Behaviour:
- Reset (asynchronous, active-low):
  - State returns to IDLE.
  - All bucket valid bits clear; valid bits are flops, key/value storage is RAM without reset.
  - req_ready_o = 1, resp_valid_o = 0, resp_hit_o = 0, resp_status_o = 00, resp_value_o = 0.
- FSM states: IDLE, READ, CMP, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i at edge N: capture op, key and value into registers; go to READ.
- READ:
  - Hash address = H3(key_q, matrix_i), combinational.
  - Bucket key/value read synchronously; result registered at edge N+1; go to CMP.
- CMP:
  - match = valid[adr] & (stored key == key_q).
  - LOOKUP: match -> hit=1, OK, value=stored; else NOT_FOUND, value=0.
  - INSERT:
    - Empty slot -> write {1, key, value}, OK, hit=0.
    - Match -> overwrite value, OK, hit=1, resp_value = old value.
    - Different valid key -> no write, COLLISION, hit=0.
  - DELETE: match -> clear valid, OK, hit=1, value=stored; else NOT_FOUND.
  - Op 11 -> ILLEGAL_OP, no table change.
  - Table write and response registers update at edge N+2; go to RESP.
- RESP:
  - resp_valid_o = 1 from edge N+2; outputs held stable until resp_valid_o & resp_ready_i.
  - On that handshake edge: go to IDLE, resp_valid_o = 0.
- Latency: minimum 2 edges from accept to response. Throughput: one request per 4 cycles with resp_ready_i held high.
- req_ready_o = 0 in READ, CMP and RESP; no request is taken while a response is pending.
- Back-to-back requests to the same bucket see the prior write (the write is committed before IDLE).
- Reset mid-operation: request discarded; any write not yet at edge N+2 is not committed; table fully cleared.
- matrix_i changes while busy are undefined; the feeding side changes it only while req_ready_o = 1 and req_valid_i = 0.

Optional Feature:
- Macro H3_TABLE_STATS_EN.
- Defined, adds two ports, both reset to 0:
  - occupancy_o, output, HASH_ADR_WIDTH+1 bits: count of valid buckets; +1 on insert into an empty slot, -1 on successful delete, unchanged on overwrite.
  - collision_cnt_o, output, 16 bits: saturating count of COLLISION responses; holds at 16'hFFFF.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Common setup: matrix row j = 32'h1 << j, so hash = key[4:0].
- Reset, then LOOKUP key 32'h0000_0003 -> NOT_FOUND, hit=0, value=0; resp_valid_o 2 edges after accept.
- INSERT 32'h0000_0003/32'hDEAD_BEEF -> OK, hit=0; LOOKUP 32'h0000_0003 -> OK, hit=1, value=32'hDEAD_BEEF.
- With 0x03 present, INSERT 32'h0000_0023/32'h1111_1111 -> COLLISION; LOOKUP 0x23 -> NOT_FOUND; LOOKUP 0x03 -> still 32'hDEAD_BEEF.
- INSERT 0x03/32'h2222_2222 -> OK, hit=1, value=32'hDEAD_BEEF; DELETE 0x03 -> OK, hit=1, value=32'h2222_2222; LOOKUP 0x03 -> NOT_FOUND.
- Hold resp_ready_i=0 for 5 cycles -> resp outputs stable, req_ready_o=0; op=11 -> ILLEGAL_OP, no change.
- Assert reset_n=0 during CMP of an INSERT to empty bucket 0x07, then LOOKUP 0x07 -> NOT_FOUND.
- With H3_TABLE_STATS_EN: 3 inserts to distinct buckets + 1 collision + 1 delete -> occupancy_o=2, collision_cnt_o=1.
